// File: rtl/enemy_spawn_scheduler.sv
// enemy_spawn_scheduler: paces enemy respawns on frame ticks, caps live
// enemies per level, picks a free slot and a rotating spawn point.
module enemy_spawn_scheduler #(
  parameter int NUM_SLOTS     = 8,
  parameter int NUM_SPAWN_PTS = 4,
  parameter int BASE_CAP      = 1
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Frame_Tick,
  input  logic                             Run,
  input  logic [3:0]                       Game_Level,
  input  logic [9:0]                       Enemy_Respawn_Unit_Time,
  input  logic [NUM_SLOTS-1:0]             Enemy_Alive,
  input  logic                             Spawn_Ack,
  output logic                             Spawn_Valid,
  output logic [$clog2(NUM_SLOTS)-1:0]     Spawn_Slot,
  output logic [$clog2(NUM_SPAWN_PTS)-1:0] Spawn_Point,
  output logic [3:0]                       Active_Cap,
  output logic                             Level_Up
);
  localparam int SW = $clog2(NUM_SLOTS);
  localparam int PW = $clog2(NUM_SPAWN_PTS);
  localparam int CW = SW + 1;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    CHECK,
    WAIT_FREE,
    REQ
  } state_t;

  state_t        state_q;
  logic [9:0]    cnt_q;
  logic          valid_q;
  logic [SW-1:0] slot_q;
  logic [PW-1:0] point_q;
  logic [3:0]    cap_q;
  logic [3:0]    prev_q;
  logic          lvl_up_q;

  logic [9:0]    unit_d;
  logic [4:0]    cap_sum;
  logic [3:0]    cap_d;
  logic [CW-1:0] live_d;
  logic [SW-1:0] free_d;
  logic          free_ok_d;
  logic          spawn_ok_d;

  // A zero unit time would never expire, so treat it as one frame.
  assign unit_d  = (Enemy_Respawn_Unit_Time == 10'd0) ?
                   10'd1 : Enemy_Respawn_Unit_Time;
  assign cap_sum = {1'b0, Game_Level} + 5'(BASE_CAP);
  assign cap_d   = (cap_sum > 5'(NUM_SLOTS)) ?
                   4'(NUM_SLOTS) : cap_sum[3:0];

  // Live-enemy popcount and lowest free slot search.
  always_comb begin
    live_d    = '0;
    free_d    = '0;
    free_ok_d = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      live_d = live_d + CW'(Enemy_Alive[i]);
      if (!Enemy_Alive[i]) begin
        free_ok_d = 1'b1;
        free_d    = SW'(i);
      end
    end
  end

  assign spawn_ok_d = free_ok_d &&
                      (16'(live_d) < 16'(cap_q));

  // Spawn sequencer with registered handshake outputs, cap and level pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      slot_q   <= '0;
      point_q  <= '0;
      cap_q    <= 4'(1 + BASE_CAP);
      prev_q   <= 4'd1;
      lvl_up_q <= 1'b0;
    end else begin
      cap_q    <= cap_d;
      prev_q   <= Game_Level;
      lvl_up_q <= (Game_Level > prev_q);
      if (!Run) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            cnt_q   <= unit_d;
            state_q <= COUNT;
          end
          COUNT: begin
            if (unit_d < cnt_q) begin
              cnt_q <= unit_d;
            end else if (Frame_Tick) begin
              if (cnt_q == 10'd1) begin
                state_q <= CHECK;
              end else begin
                cnt_q <= cnt_q - 10'd1;
              end
            end
          end
          CHECK, WAIT_FREE: begin
            if (spawn_ok_d) begin
              slot_q  <= free_d;
              valid_q <= 1'b1;
              state_q <= REQ;
            end else begin
              state_q <= WAIT_FREE;
            end
          end
          REQ: begin
            if (Spawn_Ack && valid_q) begin
              valid_q <= 1'b0;
              point_q <= point_q + PW'(1);
              cnt_q   <= unit_d;
              state_q <= COUNT;
            end
          end
          default: begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Spawn_Valid = valid_q;
  assign Spawn_Slot  = slot_q;
  assign Spawn_Point = point_q;
  assign Active_Cap  = cap_q;
  assign Level_Up    = lvl_up_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// tb_enemy_spawn_scheduler: scenario tasks with a spawn scoreboard
// holding the expected slot/point of each request.
module tb_enemy_spawn_scheduler;
  logic       Clk = 1'b0;
  logic       Reset;
  logic       Frame_Tick;
  logic       Run;
  logic [3:0] Game_Level;
  logic [9:0] Unit;
  logic [7:0] Alive;
  logic       Ack;
  logic       Valid;
  logic [2:0] Slot;
  logic [1:0] Point;
  logic [3:0] Cap;
  logic       Lvl_Up;

  typedef struct packed {
    logic [2:0] slot;
    logic [1:0] pt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  enemy_spawn_scheduler dut (
    .Clk                     (Clk),
    .Reset                   (Reset),
    .Frame_Tick              (Frame_Tick),
    .Run                     (Run),
    .Game_Level              (Game_Level),
    .Enemy_Respawn_Unit_Time (Unit),
    .Enemy_Alive             (Alive),
    .Spawn_Ack               (Ack),
    .Spawn_Valid             (Valid),
    .Spawn_Slot              (Slot),
    .Spawn_Point             (Point),
    .Active_Cap              (Cap),
    .Level_Up                (Lvl_Up)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick();
    Frame_Tick = 1'b1;
    cyc(1);
    Frame_Tick = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0; Run = 1'b1; Frame_Tick = 1'b0;
    Game_Level = 4'd1; Unit = 10'd3; Alive = 8'h00; Ack = 1'b1;
    cyc(2);
    n_chk++;
    if (Valid !== 1'b0 || Slot !== 3'd0 || Point !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got v=%b s=%0d p=%0d want 0/0/0",
               Valid, Slot, Point);
    end
    n_chk++;
    if (Lvl_Up !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_lvlup: got %b want 0", Lvl_Up);
    end
    n_chk++;
    if (Cap !== 4'd2) begin
      n_fail++;
      $display("FAIL reset_cap: got %0d want 2", Cap);
    end
  endtask

  task automatic test_points();
    exp_t e;
    Reset = 1'b1;
    cyc(1);
    for (int k = 0; k < 5; k++) begin
      sb.push_back({3'd0, 2'(k)});
      for (int t = 0; t < 3; t++) begin
        tick();
        n_chk++;
        if (Valid !== 1'b0) begin
          n_fail++;
          $display("FAIL points_early k=%0d t=%0d: got %b want 0",
                   k, t, Valid);
        end
      end
      cyc(1);
      n_chk++;
      if (Valid !== 1'b1) begin
        n_fail++;
        $display("FAIL points_valid k=%0d: got %b want 1", k, Valid);
      end
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL points_sb k=%0d: queue empty", k);
      end else begin
        e = sb.pop_front();
        if (Slot !== e.slot || Point !== e.pt) begin
          n_fail++;
          $display("FAIL points_req k=%0d: got s=%0d p=%0d want s=%0d p=%0d",
                   k, Slot, Point, e.slot, e.pt);
        end
      end
      cyc(1);
      n_chk++;
      if (Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL points_drop k=%0d: got %b want 0", k, Valid);
      end
    end
  endtask

  task automatic test_wait_free();
    exp_t e;
    Ack = 1'b0;
    Alive = 8'b0000_0011;
    for (int t = 0; t < 7; t++) begin
      tick();
      n_chk++;
      if (Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold t=%0d: got %b want 0", t, Valid);
      end
    end
    sb.push_back({3'd0, 2'd1});
    Alive = 8'b0000_0010;
    cyc(1);
    n_chk++;
    if (Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_valid: got %b want 1", Valid);
    end
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL wait_sb: queue empty");
    end else begin
      e = sb.pop_front();
      if (Slot !== e.slot || Point !== e.pt) begin
        n_fail++;
        $display("FAIL wait_req: got s=%0d p=%0d want s=%0d p=%0d",
                 Slot, Point, e.slot, e.pt);
      end
    end
    Ack = 1'b1;
    cyc(1);
    Ack = 1'b0;
    n_chk++;
    if (Valid !== 1'b0 || Point !== 2'd2) begin
      n_fail++;
      $display("FAIL wait_done: got v=%b p=%0d want v=0 p=2", Valid, Point);
    end
  endtask

  task automatic test_ack_delay();
    exp_t e;
    Game_Level = 4'd6;
    Alive = 8'b0000_0101;
    Ack = 1'b0;
    cyc(1);
    sb.push_back({3'd1, 2'd2});
    tick(); tick(); tick();
    cyc(1);
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL delay_sb: queue empty");
    end else begin
      e = sb.pop_front();
      if (Valid !== 1'b1 || Slot !== e.slot || Point !== e.pt) begin
        n_fail++;
        $display("FAIL delay_req: got v=%b s=%0d p=%0d want v=1 s=%0d p=%0d",
                 Valid, Slot, Point, e.slot, e.pt);
      end
    end
    Alive = 8'h00;
    Frame_Tick = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      n_chk++;
      if (Valid !== 1'b1 || Slot !== 3'd1 || Point !== 2'd2) begin
        n_fail++;
        $display("FAIL delay_hold c=%0d: got v=%b s=%0d p=%0d want 1/1/2",
                 c, Valid, Slot, Point);
      end
    end
    Frame_Tick = 1'b0;
    Ack = 1'b1;
    cyc(1);
    n_chk++;
    if (Valid !== 1'b0 || Point !== 2'd3) begin
      n_fail++;
      $display("FAIL delay_done: got v=%b p=%0d want v=0 p=3", Valid, Point);
    end
    cyc(2);
    n_chk++;
    if (Valid !== 1'b0 || Point !== 2'd3) begin
      n_fail++;
      $display("FAIL delay_stray_ack: got v=%b p=%0d want v=0 p=3",
               Valid, Point);
    end
    Ack = 1'b0;
  endtask

  task automatic test_run_drop();
    exp_t e;
    Alive = 8'b0000_0111;
    sb.push_back({3'd3, 2'd3});
    tick(); tick(); tick();
    cyc(1);
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL drop_sb: queue empty");
    end else begin
      e = sb.pop_front();
      if (Valid !== 1'b1 || Slot !== e.slot || Point !== e.pt) begin
        n_fail++;
        $display("FAIL drop_req: got v=%b s=%0d p=%0d want v=1 s=%0d p=%0d",
                 Valid, Slot, Point, e.slot, e.pt);
      end
    end
    Run = 1'b0;
    cyc(1);
    n_chk++;
    if (Valid !== 1'b0 || Slot !== 3'd3 || Point !== 2'd3) begin
      n_fail++;
      $display("FAIL drop_abandon: got v=%b s=%0d p=%0d want 0/3/3",
               Valid, Slot, Point);
    end
    cyc(1);
    Alive = 8'h00;
    Run = 1'b1;
    cyc(1);
    sb.push_back({3'd0, 2'd3});
    for (int t = 0; t < 3; t++) begin
      tick();
      n_chk++;
      if (Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL drop_recount t=%0d: got %b want 0", t, Valid);
      end
    end
    cyc(1);
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL drop_sb2: queue empty");
    end else begin
      e = sb.pop_front();
      if (Valid !== 1'b1 || Slot !== e.slot || Point !== e.pt) begin
        n_fail++;
        $display("FAIL drop_req2: got v=%b s=%0d p=%0d want v=1 s=%0d p=%0d",
                 Valid, Slot, Point, e.slot, e.pt);
      end
    end
    Ack = 1'b1;
    cyc(1);
    Ack = 1'b0;
    n_chk++;
    if (Valid !== 1'b0 || Point !== 2'd0) begin
      n_fail++;
      $display("FAIL drop_done: got v=%b p=%0d want v=0 p=0", Valid, Point);
    end
  endtask

  task automatic test_level_up();
    Game_Level = 4'd2;
    cyc(1);
    n_chk++;
    if (Lvl_Up !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_6to2: got %b want 0", Lvl_Up);
    end
    cyc(1);
    Game_Level = 4'd3;
    n_chk++;
    if (Cap !== 4'd3 || Lvl_Up !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_pre: got cap=%0d up=%b want 3/0", Cap, Lvl_Up);
    end
    cyc(1);
    n_chk++;
    if (Cap !== 4'd4 || Lvl_Up !== 1'b1) begin
      n_fail++;
      $display("FAIL lvl_2to3: got cap=%0d up=%b want 4/1", Cap, Lvl_Up);
    end
    cyc(1);
    n_chk++;
    if (Lvl_Up !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_pulse_len: got %b want 0", Lvl_Up);
    end
    Game_Level = 4'd1;
    cyc(1);
    n_chk++;
    if (Cap !== 4'd2 || Lvl_Up !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_3to1: got cap=%0d up=%b want 2/0", Cap, Lvl_Up);
    end
    Run = 1'b0;
    Game_Level = 4'd9;
    cyc(1);
    n_chk++;
    if (Cap !== 4'd8 || Lvl_Up !== 1'b1) begin
      n_fail++;
      $display("FAIL lvl_9: got cap=%0d up=%b want 8/1", Cap, Lvl_Up);
    end
    cyc(1);
    n_chk++;
    if (Lvl_Up !== 1'b0) begin
      n_fail++;
      $display("FAIL lvl_9_len: got %b want 0", Lvl_Up);
    end
  endtask

  task automatic test_clamp();
    exp_t e;
    Unit = 10'd40;
    Ack = 1'b1;
    Run = 1'b1;
    cyc(1);
    Unit = 10'd5;
    cyc(1);
    sb.push_back({3'd0, 2'd0});
    for (int t = 0; t < 5; t++) begin
      tick();
      n_chk++;
      if (Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clamp_early t=%0d: got %b want 0", t, Valid);
      end
    end
    cyc(1);
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL clamp_sb: queue empty");
    end else begin
      e = sb.pop_front();
      if (Valid !== 1'b1 || Slot !== e.slot || Point !== e.pt) begin
        n_fail++;
        $display("FAIL clamp_req: got v=%b s=%0d p=%0d want v=1 s=%0d p=%0d",
                 Valid, Slot, Point, e.slot, e.pt);
      end
    end
    cyc(1);
  endtask

  task automatic test_unit_zero();
    exp_t e;
    Unit = 10'd0;
    cyc(1);
    for (int k = 0; k < 4; k++) begin
      sb.push_back({3'd0, 2'(k + 1)});
      tick();
      n_chk++;
      if (Valid !== 1'b0) begin
        n_fail++;
        $display("FAIL u0_early k=%0d: got %b want 0", k, Valid);
      end
      cyc(1);
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL u0_sb k=%0d: queue empty", k);
      end else begin
        e = sb.pop_front();
        if (Valid !== 1'b1 || Slot !== e.slot || Point !== e.pt) begin
          n_fail++;
          $display("FAIL u0_req k=%0d: got v=%b s=%0d p=%0d want v=1 s=%0d p=%0d",
                   k, Valid, Slot, Point, e.slot, e.pt);
        end
      end
      cyc(1);
    end
  endtask

  task automatic test_reset_mid();
    Ack = 1'b0;
    tick();
    cyc(1);
    n_chk++;
    if (Valid !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_req: got %b want 1", Valid);
    end
    Reset = 1'b0;
    cyc(1);
    n_chk++;
    if (Valid !== 1'b0 || Point !== 2'd0 || Cap !== 4'd2) begin
      n_fail++;
      $display("FAIL rmid_drop: got v=%b p=%0d cap=%0d want 0/0/2",
               Valid, Point, Cap);
    end
    Reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_points();
    test_wait_free();
    test_ack_delay();
    test_run_drop();
    test_level_up();
    test_clamp();
    test_unit_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
